// File: rtl/mem_if_pkg.sv
// Shared encodings for the memory initiator: FSM states, response status codes, word geometry.
// No logic; constants and a single alignment helper.
// Imported by mem_initiator.
package mem_if_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [1:0] STATUS_OK         = 2'b00;
    localparam logic [1:0] STATUS_MISALIGNED = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT    = 2'b10;

    localparam int WORD_BYTES = 8;
    localparam int WORD_LSBS  = $clog2(WORD_BYTES);

    function automatic logic is_misaligned(input logic [WORD_LSBS-1:0] lsbs);
        return lsbs != '0;
    endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous request FIFO with a combinational head (fall-through read).
// Latency: a push is visible at head the cycle after the push edge.
// Backpressure: push is ignored when full, pop is ignored when empty.
module mem_req_fifo #(
    parameter int WIDTH = 81,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head  = store[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr[PTR_W-1:0]] <= push_dat;
    end

endmodule

// File: rtl/mem_initiator.sv
// Memory initiator: queues load/store requests and runs them one at a time on the Memory handshake.
// Latency: request edge N -> popped at N+1 -> enable high after N+2; response the cycle after mem_ready.
// Backpressure: req_ready drops when the FIFO is full; a held response blocks any further memory access.
module mem_initiator
    import mem_if_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 64,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_status,
    output logic                  mem_read_enable,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_ready
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    req_t             push_req;
    req_t             head_req;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [1:0]       state;
    logic             rdy_en;
    logic             mem_en;
    logic [TMO_W-1:0] tmo_cnt;

    // rdy_en keeps req_ready low through reset and until the first edge after release.
    assign req_ready = rdy_en && !fifo_full;
    assign fifo_push = req_valid && req_ready;
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
    assign mem_en    = mem_read_enable || mem_write_enable;
    assign push_req  = '{write: req_write, addr: req_addr, wdata: req_wdata};

    mem_req_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat (push_req),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head_req)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= ST_IDLE;
            rdy_en           <= 1'b0;
            tmo_cnt          <= '0;
            rsp_valid        <= 1'b0;
            rsp_write        <= 1'b0;
            rsp_rdata        <= '0;
            rsp_status       <= STATUS_OK;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_address      <= '0;
            mem_write_data   <= '0;
        end else begin
            rdy_en <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        rsp_write <= head_req.write;
                        if (is_misaligned(head_req.addr[WORD_LSBS-1:0])) begin
                            rsp_status <= STATUS_MISALIGNED;
                            rsp_rdata  <= '0;
                            rsp_valid  <= 1'b1;
                            state      <= ST_RESP;
                        end else begin
                            mem_address    <= head_req.addr;
                            mem_write_data <= head_req.wdata;
                            tmo_cnt        <= '0;
                            state          <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    // First ACCESS cycle only raises the enable; address/data were set up a cycle earlier.
                    if (!mem_en) begin
                        mem_write_enable <= rsp_write;
                        mem_read_enable  <= !rsp_write;
                    end else if (mem_ready) begin
                        mem_read_enable  <= 1'b0;
                        mem_write_enable <= 1'b0;
                        rsp_rdata        <= rsp_write ? '0 : mem_read_data;
                        rsp_status       <= STATUS_OK;
                        rsp_valid        <= 1'b1;
                        state            <= ST_RESP;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        mem_read_enable  <= 1'b0;
                        mem_write_enable <= 1'b0;
                        rsp_rdata        <= '0;
                        rsp_status       <= STATUS_TIMEOUT;
                        rsp_valid        <= 1'b1;
                        state            <= ST_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
